// File: rtl/alu_iter.sv
// Iterative execute-stage ALU: single-cycle base integer ops plus RV32M
// multiply/divide/remainder computed one bit per cycle behind valid/ready.
module alu_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       funct3,
  input  logic             is_rtype,
  input  logic             bit30,
  input  logic             is_muldiv,
  input  logic             pass_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Multiply: {partial sum, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               hi_q, hi_d;
  logic               rem_q, rem_d;

  // ---------------------------------------------------------------------------
  // Base single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   base_res;

  assign shamt = op_b[SHAMT_W-1:0];

  // Base op decode; pass_b (LUI) overrides funct3.
  always_comb begin
    base_res = '0;
    if (pass_b) begin
      base_res = op_b;
    end else begin
      unique case (funct3)
        3'd0: base_res = (is_rtype && bit30) ? (op_a - op_b) : (op_a + op_b);
        3'd1: base_res = op_a << shamt;
        3'd2: base_res = WIDTH'($signed(op_a) < $signed(op_b));
        3'd3: base_res = WIDTH'(op_a < op_b);
        3'd4: base_res = op_a ^ op_b;
        3'd5: base_res = bit30 ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
        3'd6: base_res = op_a | op_b;
        3'd7: base_res = op_a & op_b;
        default: base_res = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // M-extension operand preparation and fast-path special cases
  // ---------------------------------------------------------------------------
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_res;

  // Signedness per funct3: MULH s/s, MULHSU s/u, MUL/MULHU u/u, DIV/REM s/s, DIVU/REMU u/u.
  always_comb begin
    if (funct3[2]) begin
      a_sgn = ~funct3[0];
      b_sgn = ~funct3[0];
    end else begin
      a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_sgn = (funct3[1:0] == 2'b01);
    end
    a_neg    = a_sgn & op_a[WIDTH-1];
    b_neg    = b_sgn & op_b[WIDTH-1];
    a_mag    = a_neg ? (-op_a) : op_a;
    b_mag    = b_neg ? (-op_b) : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MinNeg) && (op_b == '1);
    fast     = div_zero || div_ovf;
    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder = 0.
    if (div_zero) begin
      fast_res = funct3[1] ? op_a : '1;
    end else begin
      fast_res = funct3[1] ? '0 : op_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply / restoring divide
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial, diff;
  logic               ge;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_val;
  logic [WIDTH-1:0]   final_res;

  // Datapath for the current iteration and the sign-corrected final value.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge       = trial >= {1'b0, opb_q};
    diff     = trial - {1'b0, opb_q};
    // Remainder stays below the divisor, so a restored difference fits in WIDTH bits.
    new_rem  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    div_next = {new_rem, acc_q[WIDTH-2:0], ge};

    step = is_div_q ? div_next : mul_next;

    prod    = neg_q ? (-step) : step;
    div_val = rem_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    if (is_div_q) begin
      final_res = neg_q ? (-div_val) : div_val;
    end else begin
      final_res = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state, operand capture and result update; flush overrides all of it.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    rem_d    = rem_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_muldiv && !pass_b && !fast) begin
            state_d  = StBusy;
            cnt_d    = '0;
            is_div_d = funct3[2];
            hi_d     = (funct3[1:0] != 2'b00);
            rem_d    = funct3[1];
            if (funct3[2]) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              opb_d = b_mag;
              neg_d = funct3[1] ? a_neg : (a_neg ^ b_neg);
            end else begin
              acc_d = {{WIDTH{1'b0}}, b_mag};
              opb_d = a_mag;
              neg_d = a_neg ^ b_neg;
            end
          end else begin
            state_d  = StDone;
            result_d = (is_muldiv && !pass_b) ? fast_res : base_res;
          end
        end
      end
      StBusy: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          cnt_d    = '0;
          result_d = final_res;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
      cnt_d    = '0;
      acc_d    = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      rem_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      rem_q    <= rem_d;
    end
  end

  // Not ready while reset is held so nothing is accepted during the reset cycle.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=32 and WIDTH=16.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst32, rst16;
  logic        iv32, iv16, or32, or16, flush;
  logic [31:0] op_a, op_b;
  logic [2:0]  f3;
  logic        rt, b30, md, pb;
  logic        rdy32, ov32, rdy16, ov16;
  logic [31:0] res32;
  logic [15:0] res16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32), .SHAMT_W(5)) u_dut32 (
    .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(rdy32),
    .op_a(op_a), .op_b(op_b), .funct3(f3), .is_rtype(rt), .bit30(b30),
    .is_muldiv(md), .pass_b(pb), .flush(flush), .out_valid(ov32),
    .out_ready(or32), .result(res32)
  );

  alu_iter #(.WIDTH(16), .SHAMT_W(4)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(rdy16),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .funct3(f3), .is_rtype(rt), .bit30(b30),
    .is_muldiv(md), .pass_b(pb), .flush(1'b0), .out_valid(ov16),
    .out_ready(or16), .result(res16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Golden model for the 16-bit M ops using native wide arithmetic.
  function automatic logic [15:0] model16(input logic [2:0] f, input logic [15:0] a,
                                          input logic [15:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({48'd0, a});
    longint      ub = longint'({48'd0, b});
    logic [63:0] pv;
    case (f)
      3'd0: begin pv = ua * ub; return pv[15:0]; end
      3'd1: begin pv = sa * sb; return pv[31:16]; end
      3'd2: begin pv = sa * ub; return pv[31:16]; end
      3'd3: begin pv = ua * ub; return pv[31:16]; end
      3'd4: begin
        if (b == 16'h0) return 16'hFFFF;
        if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
        pv = sa / sb; return pv[15:0];
      end
      3'd5: begin
        if (b == 16'h0) return 16'hFFFF;
        pv = ua / ub; return pv[15:0];
      end
      3'd6: begin
        if (b == 16'h0) return a;
        if (a == 16'h8000 && b == 16'hFFFF) return 16'h0;
        pv = sa % sb; return pv[15:0];
      end
      default: begin
        if (b == 16'h0) return a;
        pv = ua % ub; return pv[15:0];
      end
    endcase
  endfunction

  // Issue one request, measure latency, optionally hold off the consumer, then drain.
  task automatic run(input bit w16, input logic [2:0] f, input bit m, input bit r,
                     input bit s30, input bit p, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_v, input int exp_lat, input int hold,
                     input string tag);
    int          lat;
    bit          busy_rdy;
    bit          bad;
    logic [31:0] r0;
    f3 = f; md = m; rt = r; b30 = s30; pb = p; op_a = a; op_b = b;
    if (w16) iv16 = 1'b1; else iv32 = 1'b1;
    check({tag, ".in_ready"}, w16 ? rdy16 : rdy32, 32'd1);
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    // Scramble inputs: the captured request must be unaffected.
    op_a = ~a; op_b = ~b; f3 = ~f; md = ~m; pb = ~p;
    lat = 1; busy_rdy = 1'b0;
    while (!(w16 ? ov16 : ov32) && lat < 200) begin
      if (w16 ? rdy16 : rdy32) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_ready"}, busy_rdy, 32'd0);
    r0 = w16 ? {16'h0, res16} : res32;
    check({tag, ".result"}, r0, exp_v);
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!(w16 ? ov16 : ov32) || (w16 ? rdy16 : rdy32) ||
          ((w16 ? {16'h0, res16} : res32) !== r0)) bad = 1'b1;
    end
    if (hold > 0) check({tag, ".hold_stable"}, bad, 32'd0);
    if (w16) or16 = 1'b1; else or32 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0; or32 = 1'b0;
    check({tag, ".drain"}, w16 ? {ov16, rdy16} : {ov32, rdy32}, 32'd1);
  endtask

  initial begin
    bit          bad;
    logic [2:0]  rf;
    logic [15:0] ra, rb;
    int          rl;

    rst32 = 1'b1; rst16 = 1'b1; iv32 = 1'b0; iv16 = 1'b0; or32 = 1'b0; or16 = 1'b0;
    flush = 1'b0; op_a = '0; op_b = '0; f3 = '0; rt = 1'b0; b30 = 1'b0; md = 1'b0; pb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", rdy32, 32'd0);
    check("reset.out_valid", ov32, 32'd0);
    check("reset.result", res32, 32'd0);
    check("reset.result16", {16'h0, res16}, 32'd0);
    rst32 = 1'b0; rst16 = 1'b0;
    #1;
    check("post_reset.in_ready", {rdy32, rdy16}, 32'd3);

    // Base ops.
    run(0, 3'd0, 0, 1, 1, 0, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 0, "sub");
    run(0, 3'd5, 0, 0, 1, 0, 32'h80000000, 32'd4, 32'hF8000000, 1, 0, "srai");
    run(0, 3'd5, 0, 1, 0, 0, 32'h80000000, 32'd4, 32'h08000000, 1, 0, "srl");
    run(0, 3'd1, 0, 0, 0, 0, 32'h00000003, 32'd33, 32'h00000006, 1, 0, "sll_shamt");
    run(0, 3'd2, 0, 1, 0, 0, 32'hFFFFFFFF, 32'd5, 32'd1, 1, 0, "slt");
    run(0, 3'd3, 0, 1, 0, 0, 32'hFFFFFFFF, 32'd5, 32'd0, 1, 0, "sltu");
    run(0, 3'd4, 0, 1, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, "xor");
    run(0, 3'd7, 0, 1, 0, 1, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1, 0, "lui");

    // Multiply.
    run(0, 3'd0, 1, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 0, "mul");
    run(0, 3'd3, 1, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu");
    run(0, 3'd1, 1, 1, 0, 0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 33, 0, "mulh");
    run(0, 3'd2, 1, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, "mulhsu");

    // Divide.
    run(0, 3'd4, 1, 1, 0, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, "div");
    run(0, 3'd6, 1, 1, 0, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, "rem");
    run(0, 3'd5, 1, 1, 0, 0, 32'd100, 32'd7, 32'd14, 33, 0, "divu");
    run(0, 3'd7, 1, 1, 0, 0, 32'd100, 32'd7, 32'd2, 33, 0, "remu");

    // Fast-path special cases.
    run(0, 3'd4, 1, 1, 0, 0, 32'd1234, 32'd0, 32'hFFFFFFFF, 1, 0, "div_by0");
    run(0, 3'd7, 1, 1, 0, 0, 32'd9, 32'd0, 32'd9, 1, 0, "remu_by0");
    run(0, 3'd4, 1, 1, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "div_ovf");
    run(0, 3'd6, 1, 1, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0, "rem_ovf");

    // Backpressure: consumer stalls 10 cycles after a MUL completes.
    run(0, 3'd0, 1, 1, 0, 0, 32'd12345, 32'd1000, 32'd12345000, 33, 10, "mul_bp");

    // Flush at BUSY cycle 10, with an ADD presented in the same cycle.
    f3 = 3'd0; md = 1'b1; rt = 1'b1; b30 = 1'b0; pb = 1'b0;
    op_a = 32'd77; op_b = 32'd88; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; iv32 = 1'b1; md = 1'b0; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    flush = 1'b0; iv32 = 1'b0;
    check("flush.state", {ov32, rdy32}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32) bad = 1'b1;
    end
    check("flush.no_out_valid", bad, 32'd0);
    run(0, 3'd0, 0, 1, 0, 0, 32'd1, 32'd2, 32'd3, 1, 0, "add_after_flush");

    // WIDTH=16.
    run(1, 3'd0, 1, 1, 0, 0, 32'h1234, 32'h0010, 32'h2340, 17, 0, "w16.mul");
    run(1, 3'd4, 1, 1, 0, 0, 32'h8000, 32'hFFFF, 32'h8000, 1, 0, "w16.div_ovf");
    run(1, 3'd6, 1, 1, 0, 0, 32'hFFF9, 32'h0002, 32'hFFFF, 17, 0, "w16.rem");
    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 4) rb = 16'h0;
      if (i == 7) begin rf = 3'd6; ra = 16'h8000; rb = 16'hFFFF; end
      rl = (rf[2] && (rb == 16'h0 || (!rf[0] && ra == 16'h8000 && rb == 16'hFFFF))) ? 1 : 17;
      run(1, rf, 1, 1, 0, 0, {16'h0, ra}, {16'h0, rb}, {16'h0, model16(rf, ra, rb)}, rl, 0,
          $sformatf("w16.rand%0d.f%0d", i, rf));
    end

    // Reset in the middle of a 16-bit multiply.
    f3 = 3'd0; md = 1'b1; rt = 1'b1; pb = 1'b0; op_a = 32'h00FF; op_b = 32'h0101; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst16 = 1'b1;
    @(posedge clk); #1;
    check("w16.rst_busy.out_valid", ov16, 32'd0);
    check("w16.rst_busy.result", {16'h0, res16}, 32'd0);
    check("w16.rst_busy.in_ready", rdy16, 32'd0);
    rst16 = 1'b0;
    #1;
    check("w16.rst_busy.ready_after", rdy16, 32'd1);
    run(1, 3'd5, 1, 1, 0, 0, 32'd100, 32'd7, 32'd14, 17, 0, "w16.divu_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
